bin2csd_seq: RTL and testbench

Sequential binary-to-CSD (canonical signed digit) encoder and the inverse of the csd2bin converter. Takes a W-bit two's-complement operand and produces the W-digit non-adjacent CSD form, LSB-first, one digit per clock, using Reitwiesner recoding. Feeds CSD operands to the BKM FPU datapath and closes the csd2bin round-trip in verification.

---
 rtl/bin2csd_seq_pkg.sv | 25 ++
 rtl/bin2csd_seq_if.sv | 47 ++++
 rtl/csd_recode_cell.sv | 33 +++
 rtl/bin2csd_seq.sv | 124 ++++++++++++
 tb/tb_bin2csd_seq.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/bin2csd_seq_pkg.sv
// ---------------------------------------------------------------------------
// bin2csd_seq_pkg
// Shared definitions for the binary-to-CSD encoder. These are the same values
// the csd2bin decoder uses:
//   CSD_ZERO / CSD_POS / CSD_NEG : 2-bit signed-digit codes (2'b10 unused)
//   state_t                      : ST_IDLE / ST_CONV / ST_DONE encodings
//   csd_is_nonzero()             : helper that flags a non-zero digit
// ---------------------------------------------------------------------------
package bin2csd_seq_pkg;

  localparam logic [1:0] CSD_ZERO = 2'b00;
  localparam logic [1:0] CSD_POS  = 2'b01;
  localparam logic [1:0] CSD_NEG  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CONV = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  function automatic logic csd_is_nonzero(input logic [1:0] d);
    return d != CSD_ZERO;
  endfunction

endpackage

// File: rtl/bin2csd_seq_if.sv
// ---------------------------------------------------------------------------
// bin2csd_seq_if
// Operand/result handshake bundle for bin2csd_seq.
//   in_valid/in_ready/x    : operand channel (producer -> encoder)
//   out_valid/out_ready/y  : CSD result channel (encoder -> consumer)
//   busy                   : conversion in progress
//   nz_cnt                 : non-zero digit count (only with BIN2CSD_NZ_CNT_EN)
// The master modport is the producer/consumer side. The slave modport is the
// encoder side.
// ---------------------------------------------------------------------------
interface bin2csd_seq_if #(
  parameter int W = 15
);
  localparam int CW = $clog2(W + 1);

  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   x;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] y;
  logic           busy;
`ifdef BIN2CSD_NZ_CNT_EN
  logic [CW-1:0]  nz_cnt;

  modport master (
    output in_valid, x, out_ready,
    input  in_ready, out_valid, y, busy, nz_cnt
  );

  modport slave (
    input  in_valid, x, out_ready,
    output in_ready, out_valid, y, busy, nz_cnt
  );
`else
  modport master (
    output in_valid, x, out_ready,
    input  in_ready, out_valid, y, busy
  );

  modport slave (
    input  in_valid, x, out_ready,
    output in_ready, out_valid, y, busy
  );
`endif

endinterface

// File: rtl/csd_recode_cell.sv
// ---------------------------------------------------------------------------
// csd_recode_cell
// One Reitwiesner recoding step. It is purely combinational.
//   x_i, x_ip1 : current operand bit and the next-higher operand bit
//   c_i        : incoming carry
//   d          : CSD digit (CSD_ZERO / CSD_POS / CSD_NEG)
//   c_next     : outgoing carry = floor((x_i + x_ip1 + c_i) / 2)
// ---------------------------------------------------------------------------
module csd_recode_cell
  import bin2csd_seq_pkg::*;
(
  input  logic       x_i,
  input  logic       x_ip1,
  input  logic       c_i,
  output logic [1:0] d,
  output logic       c_next
);

  logic odd;

  // The digit is non-zero only when x_i + c_i is odd. Its sign is taken from
  // x_ip1: a one above forces a carry out, and that carry turns the digit
  // into -1.
  always_comb begin
    odd    = x_i ^ c_i;
    c_next = (x_i & c_i) | (odd & x_ip1);
    d      = CSD_ZERO;
    if (odd) begin
      d = x_ip1 ? CSD_NEG : CSD_POS;
    end
  end

endmodule

// File: rtl/bin2csd_seq.sv
// ---------------------------------------------------------------------------
// bin2csd_seq
// Sequential binary-to-CSD encoder (Reitwiesner recoding). It produces one
// digit per clock, LSB first. The output is the W-digit non-adjacent form of a
// W-bit two's-complement operand.
//   clk   : system clock, rising edge
//   rst_n : asynchronous reset, active-low
//   bus   : bin2csd_seq_if.slave (operand in, CSD result out, busy)
// Digit i of bus.y sits at y[2i+1:2i].
// Optional feature: define BIN2CSD_NZ_CNT_EN to add bus.nz_cnt. This output
// counts the non-zero digits of the current conversion.
// ---------------------------------------------------------------------------
module bin2csd_seq
  import bin2csd_seq_pkg::*;
#(
  parameter int W = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  bin2csd_seq_if.slave bus
);

  localparam int            CW   = $clog2(W + 1);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_t         state_q, state_d;
  logic [W-1:0]   x_sr_q, x_sr_d;
  logic           carry_q, carry_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*W-1:0] y_q, y_d;
  logic [1:0]     digit;
  logic           carry_next;
`ifdef BIN2CSD_NZ_CNT_EN
  logic [CW-1:0]  nz_cnt_q, nz_cnt_d;
`endif

  // Serial recoding cell. It always looks at the two lowest bits of the shift
  // register. The register shifts arithmetically, so on the final step x_sr_q[1]
  // already holds the sign bit. That gives the x_W = x_{W-1} extension for free.
  csd_recode_cell u_cell (
    .x_i    (x_sr_q[0]),
    .x_ip1  (x_sr_q[1]),
    .c_i    (carry_q),
    .d      (digit),
    .c_next (carry_next)
  );

  // State and datapath registers. Reset discards any partial conversion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      x_sr_q   <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      y_q      <= '0;
`ifdef BIN2CSD_NZ_CNT_EN
      nz_cnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      x_sr_q   <= x_sr_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      y_q      <= y_d;
`ifdef BIN2CSD_NZ_CNT_EN
      nz_cnt_q <= nz_cnt_d;
`endif
    end
  end

  // Next-state and datapath update. In DONE, y is held while the consumer
  // stalls. New operands are accepted only in IDLE.
  always_comb begin
    state_d  = state_q;
    x_sr_d   = x_sr_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    y_d      = y_q;
`ifdef BIN2CSD_NZ_CNT_EN
    nz_cnt_d = nz_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          x_sr_d   = bus.x;
          carry_d  = 1'b0;
          cnt_d    = '0;
`ifdef BIN2CSD_NZ_CNT_EN
          nz_cnt_d = '0;
`endif
          state_d  = ST_CONV;
        end
      end
      ST_CONV: begin
        // After W shifts, digit 0 has reached the bottom of y.
        y_d     = {digit, y_q[2*W-1:2]};
        x_sr_d  = {x_sr_q[W-1], x_sr_q[W-1:1]};
        carry_d = carry_next;
        cnt_d   = cnt_q + 1'b1;
`ifdef BIN2CSD_NZ_CNT_EN
        nz_cnt_d = nz_cnt_q + CW'(csd_is_nonzero(digit));
`endif
        if (cnt_q == LAST) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.busy      = (state_q == ST_CONV);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.y         = y_q;
`ifdef BIN2CSD_NZ_CNT_EN
  assign bus.nz_cnt    = nz_cnt_q;
`endif

endmodule

// File: tb/tb_bin2csd_seq.sv
// ---------------------------------------------------------------------------
// tb_bin2csd_seq
// Directed self-checking bench for bin2csd_seq (W = 15). It checks the
// following:
//   - reset state
//   - hand-computed CSD vectors and the range extremes
//   - latency
//   - backpressure, including in_valid pulsed during a stall
//   - reset in the middle of a conversion
//   - a batch of random operands decoded back to an integer
// nz_cnt is checked when BIN2CSD_NZ_CNT_EN is defined.
// ---------------------------------------------------------------------------
module tb_bin2csd_seq;

  localparam int W = 15;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fails  = 0;
  int   lat;

  bin2csd_seq_if #(.W(W)) bus ();

  bin2csd_seq #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports any failure.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Decodes a CSD word into its integer value, independently of the encoder.
  function automatic int csdValue(input logic [2*W-1:0] yv);
    int acc = 0;
    for (int i = 0; i < W; i++) begin
      if (yv[2*i +: 2] == 2'b01) acc += (1 << i);
      else if (yv[2*i +: 2] == 2'b11) acc -= (1 << i);
    end
    return acc;
  endfunction

  // Returns 1 when there is no reserved 2'b10 code and no two adjacent
  // non-zero digits.
  function automatic logic csdWellFormed(input logic [2*W-1:0] yv);
    logic ok = 1'b1;
    for (int i = 0; i < W; i++) begin
      if (yv[2*i +: 2] == 2'b10) ok = 1'b0;
      if (i > 0 && yv[2*i +: 2] != 2'b00 && yv[2*(i-1) +: 2] != 2'b00) ok = 1'b0;
    end
    return ok;
  endfunction

  // Presents an operand and waits for out_valid. lat counts the clock edges
  // from the accepting edge (inclusive) to the first edge after which
  // out_valid is high. Counting the cycle in which the operand is presented,
  // the expected value is W+1.
  task automatic applyStimulus(input string tag, input logic [W-1:0] xv, output int lat_o);
    int g = 0;
    while (!bus.in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    checkOutput({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    bus.x        = xv;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    checkOutput({tag, "_busy"}, 64'(bus.busy), 64'd1);
    lat_o = 1;
    while (!bus.out_valid && lat_o < 4 * W) begin
      @(posedge clk);
      @(negedge clk);
      lat_o++;
    end
  endtask

  task automatic releaseOutput(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    checkOutput({tag, "_ov_drop"}, 64'(bus.out_valid), 64'd0);
    checkOutput({tag, "_idle"}, 64'(bus.in_ready), 64'd1);
  endtask

  task automatic convertAndCheck(input string tag, input logic [W-1:0] xv, input logic [2*W-1:0] exp_y);
    applyStimulus(tag, xv, lat);
    checkOutput({tag, "_lat"}, 64'(lat), 64'(W + 1));
    checkOutput({tag, "_y"}, 64'(bus.y), 64'(exp_y));
    releaseOutput(tag);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [W-1:0] rx;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.x         = '0;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_y", 64'(bus.y), 64'd0);
    checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("rst_busy", 64'(bus.busy), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Directed vectors with hand-computed CSD results
    convertAndCheck("zero",  15'h0000, 30'h00000000);
    convertAndCheck("one",   15'h0001, 30'h00000001);
    convertAndCheck("three", 15'h0003, 30'h00000013);

    applyStimulus("plus7", 15'h0007, lat);
    checkOutput("plus7_lat", 64'(lat), 64'(W + 1));
    checkOutput("plus7_y", 64'(bus.y), 64'h43);
`ifdef BIN2CSD_NZ_CNT_EN
    checkOutput("plus7_nz", 64'(bus.nz_cnt), 64'd2);
`endif
    releaseOutput("plus7");

    applyStimulus("minus1", 15'h7FFF, lat);
    checkOutput("minus1_lat", 64'(lat), 64'(W + 1));
    checkOutput("minus1_y", 64'(bus.y), 64'h3);
`ifdef BIN2CSD_NZ_CNT_EN
    checkOutput("minus1_nz", 64'(bus.nz_cnt), 64'd1);
`endif
    releaseOutput("minus1");

    convertAndCheck("most_neg", 15'h4000, 30'h30000000);
    convertAndCheck("most_pos", 15'h3FFF, 30'h10000003);

    // Backpressure: hold DONE for 20 cycles and pulse in_valid while stalled.
    applyStimulus("stall", 15'h3FFF, lat);
    checkOutput("stall_y0", 64'(bus.y), 64'h10000003);
    for (int i = 0; i < 20; i++) begin
      bus.in_valid = (i % 4 == 0);
      bus.x        = 15'h0007;
      @(posedge clk);
      @(negedge clk);
      checkOutput("stall_y", 64'(bus.y), 64'h10000003);
      checkOutput("stall_ov", 64'(bus.out_valid), 64'd1);
      checkOutput("stall_in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.in_valid = 1'b0;
    releaseOutput("stall");
    repeat (2) @(negedge clk);
    checkOutput("stall_no_accept", 64'(bus.busy), 64'd0);

    // Reset during the 5th CONV cycle
    @(negedge clk);
    bus.x        = 15'h1234;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput("midrst_busy_before", 64'(bus.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_y", 64'(bus.y), 64'd0);
    checkOutput("midrst_ov", 64'(bus.out_valid), 64'd0);
    checkOutput("midrst_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    convertAndCheck("after_rst", 15'h0007, 30'h00000043);

    // Random operands decoded back to an integer
    for (int k = 0; k < 40; k++) begin
      rx = W'($urandom);
      applyStimulus("rt", rx, lat);
      checkOutput("rt_value", 64'(csdValue(bus.y)), 64'(int'($signed(rx))));
      checkOutput("rt_form", 64'(csdWellFormed(bus.y)), 64'd1);
      releaseOutput("rt");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
